drive_sequencer: RTL and testbench
==================================

Name: drive_sequencer

Overview:
Registered command sequencer between the command sources (UART manual decoder, ultrasonic autonomous logic) and the H-bridge / PWM stage. Selects the active source from mode and inserts dead-time on every direction reversal and source switch. Applies a watchdog to manual commands and ramps the speed level up gradually. Drives A1..A4 and the 2-bit speed level consumed by the PWM generator.

Parameters:
DEAD_CYCLES, 50000, cycles all bridge inputs are held low on a reversal or mode switch (1 ms @ 50 MHz); must be >=1.
WDOG_CYCLES, 25000000, manual-mode cycles without m_cmd_valid before a forced stop.
RAMP_CYCLES, 5000000, cycles per +1 speed step while accelerating; must be >=1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
mode  in  2  2'b10 = autonomous, any other value = manual
m_cmd_valid  in  1  one-cycle pulse, new manual command byte decoded
m_run, m_backward, m_turn_left, m_turn_right  in  1 each  manual request bits
m_speed  in  2  manual speed level
a_run, a_backward, a_turn_left, a_turn_right  in  1 each  autonomous request bits
A1, A2  out  1 each  drive bridge: forward, reverse
A3, A4  out  1 each  steer bridge: left, right
speed  out  2  PWM level to the PWM generator
dead_active  out  1  high while in DEAD
wdog_timeout  out  1  high while the manual watchdog has expired

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. All outputs are registered.
- Reset values: A1..A4=0, speed=0, dead_active=0, wdog_timeout=1, state RUN, applied drive=STOP, applied steer=NONE, all counters 0.
- Source select: auto = (mode==2'b10). Request bits come from the a_* inputs when auto, otherwise from the m_* inputs.
- Drive decode: FWD = run&~back; REV = ~run&back; otherwise STOP.
- Steer decode: LEFT = left&~right; RIGHT = ~left&right; otherwise NONE.
- Watchdog:
  - Counter resets on m_cmd_valid, while auto, and on rst.
  - Otherwise it increments, saturating at WDOG_CYCLES.
  - wdog_timeout=1 when the counter reaches WDOG_CYCLES in manual mode. It clears the cycle after an m_cmd_valid and is 0 whenever auto.
  - m_cmd_valid wins over expiry in the same cycle.
  - While wdog_timeout=1 the effective request is STOP/NONE.
- FSM, two states:
  - RUN:
    - A1=applied==FWD, A2=applied==REV, A3=steer==LEFT, A4=steer==RIGHT.
    - Go to DEAD and zero the dead counter if either of these holds:
      - (a) the effective drive request is non-STOP and differs from a non-STOP applied drive (FWD<->REV), or the same for steer (LEFT<->RIGHT);
      - (b) auto differs from its value registered the previous cycle.
    - Otherwise load the effective request into the applied registers. Outputs update one cycle after the input change (latency 1).
    - Transitions to or from STOP/NONE never trigger DEAD.
  - DEAD:
    - A1..A4=0, speed=0, dead_active=1.
    - Counter increments each cycle. When it reaches DEAD_CYCLES-1, load the current effective request into the applied registers and return to RUN. New bridge values are visible on the next cycle.
    - Request changes during DEAD do not restart the counter; only the latest request at exit is applied.
    - A mode change during DEAD does not restart the counter.
- Speed:
  - target = 2'b11 when auto, m_speed otherwise.
  - In DEAD, or when applied drive = STOP: speed=0 and the ramp counter is cleared.
  - In RUN with speed<target: increment speed by 1 every RAMP_CYCLES cycles.
  - speed>target: load target immediately (braking is not ramped).
  - speed==target: hold, ramp counter cleared.
  - Speed never wraps; max 2'b11.
- Reset mid-DEAD or mid-ramp returns to the reset values on the next edge. No pending command survives reset.

Test Plan:
Bench overrides: DEAD_CYCLES=4, WDOG_CYCLES=20, RAMP_CYCLES=3.
1. After rst, mode=00, pulse m_cmd_valid with m_run=1, m_speed=11 -> next cycle A1=1, A2=0, wdog_timeout=0. speed goes 0->1->2->3 with one step every 3 cycles.
2. While running FWD at speed 3, switch to m_backward=1, m_run=0 -> dead_active=1 and A1..A4=0, speed=0 for exactly 4 cycles; then A2=1. speed re-ramps from 0.
3. Manual steer LEFT, then m_turn_right=1, m_turn_left=0 mid-DEAD of a drive reversal -> at DEAD exit A4=1, A3=0, with no extra dead period.
4. Manual FWD, then no m_cmd_valid for 20 cycles -> wdog_timeout=1, A1=0, speed=0. A later m_cmd_valid with FWD -> A1=1 next cycle, timeout cleared.
5. Manual FWD at m_speed=01, then mode 00->10 with a_run=1 -> 4-cycle DEAD, then A1=1 and speed ramps to 3. Watchdog stays clear indefinitely in auto.
6. Assert rst during DEAD and during a ramp -> next cycle all outputs 0 and wdog_timeout=1. Simultaneous m_cmd_valid with watchdog expiry -> timeout stays 0.

Source files
------------

// File: rtl/drive_sequencer.sv
// Command sequencer feeding the H-bridge and PWM stage: source select,
// dead-time on reversals/source switches, manual watchdog and speed ramp.
module drive_sequencer #(
  parameter int unsigned DEAD_CYCLES = 50000,
  parameter int unsigned WDOG_CYCLES = 25000000,
  parameter int unsigned RAMP_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       m_cmd_valid,
  input  logic       m_run,
  input  logic       m_backward,
  input  logic       m_turn_left,
  input  logic       m_turn_right,
  input  logic [1:0] m_speed,
  input  logic       a_run,
  input  logic       a_backward,
  input  logic       a_turn_left,
  input  logic       a_turn_right,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       A4,
  output logic [1:0] speed,
  output logic       dead_active,
  output logic       wdog_timeout
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam int RW = $clog2(RAMP_CYCLES + 1);

  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
  localparam logic [WW-1:0] WDOG_MAX  = WW'(WDOG_CYCLES);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_CYCLES - 1);

  typedef enum logic {ST_RUN, ST_DEAD} state_e;
  typedef enum logic [1:0] {DRV_STOP, DRV_FWD, DRV_REV} drv_e;
  typedef enum logic [1:0] {STR_NONE, STR_LEFT, STR_RIGHT} str_e;

  state_e          state_q, state_d;
  drv_e            drv_q, drv_d, drv_req;
  str_e            str_q, str_d, str_req;
  logic            auto_q;
  logic [DW-1:0]   dead_cnt_q, dead_cnt_d;
  logic [WW-1:0]   wdog_cnt_q, wdog_cnt_d;
  logic            wdog_to_q, wdog_to_d;
  logic [RW-1:0]   ramp_cnt_q, ramp_cnt_d;
  logic [1:0]      speed_q, speed_d;
  logic            a1_q, a2_q, a3_q, a4_q, dead_q;

  logic            auto, blocked;
  logic            run, back, left, right;
  logic            reversal;
  logic [1:0]      target;

  assign auto = (mode == 2'b10);

  always_comb begin
    run   = auto ? a_run        : m_run;
    back  = auto ? a_backward   : m_backward;
    left  = auto ? a_turn_left  : m_turn_left;
    right = auto ? a_turn_right : m_turn_right;
  end

  // A fresh manual command overrides an expired watchdog in the same cycle.
  assign blocked = wdog_to_q & ~auto & ~m_cmd_valid;

  always_comb begin
    drv_req = DRV_STOP;
    str_req = STR_NONE;
    if (!blocked) begin
      unique case (1'b1)
        run & ~back: drv_req = DRV_FWD;
        ~run & back: drv_req = DRV_REV;
        default:     drv_req = DRV_STOP;
      endcase
      unique case (1'b1)
        left & ~right: str_req = STR_LEFT;
        ~left & right: str_req = STR_RIGHT;
        default:       str_req = STR_NONE;
      endcase
    end
  end

  assign reversal =
    (drv_req != DRV_STOP && drv_q != DRV_STOP && drv_req != drv_q) ||
    (str_req != STR_NONE && str_q != STR_NONE && str_req != str_q);

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    wdog_to_d  = wdog_to_q;
    if (m_cmd_valid || auto) begin
      wdog_cnt_d = '0;
      wdog_to_d  = 1'b0;
    end else begin
      if (wdog_cnt_q != WDOG_MAX) wdog_cnt_d = wdog_cnt_q + 1'b1;
      if (wdog_cnt_d == WDOG_MAX) wdog_to_d = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    drv_d      = drv_q;
    str_d      = str_q;
    dead_cnt_d = dead_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (reversal || auto != auto_q) begin
          state_d    = ST_DEAD;
          dead_cnt_d = '0;
        end else begin
          drv_d = drv_req;
          str_d = str_req;
        end
      end
      ST_DEAD: begin
        if (dead_cnt_q == DEAD_LAST) begin
          state_d    = ST_RUN;
          drv_d      = drv_req;
          str_d      = str_req;
          dead_cnt_d = '0;
        end else begin
          dead_cnt_d = dead_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign target = auto ? 2'b11 : m_speed;

  // Acceleration is ramped; braking to a lower target is immediate.
  always_comb begin
    speed_d    = speed_q;
    ramp_cnt_d = ramp_cnt_q;
    if (state_d == ST_DEAD || drv_d == DRV_STOP) begin
      speed_d    = 2'b00;
      ramp_cnt_d = '0;
    end else if (speed_q >= target) begin
      speed_d    = target;
      ramp_cnt_d = '0;
    end else if (ramp_cnt_q == RAMP_LAST) begin
      speed_d    = speed_q + 2'b01;
      ramp_cnt_d = '0;
    end else begin
      ramp_cnt_d = ramp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      drv_q      <= DRV_STOP;
      str_q      <= STR_NONE;
      auto_q     <= 1'b0;
      dead_cnt_q <= '0;
      wdog_cnt_q <= '0;
      wdog_to_q  <= 1'b1;
      ramp_cnt_q <= '0;
      speed_q    <= 2'b00;
      a1_q       <= 1'b0;
      a2_q       <= 1'b0;
      a3_q       <= 1'b0;
      a4_q       <= 1'b0;
      dead_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      drv_q      <= drv_d;
      str_q      <= str_d;
      auto_q     <= auto;
      dead_cnt_q <= dead_cnt_d;
      wdog_cnt_q <= wdog_cnt_d;
      wdog_to_q  <= wdog_to_d;
      ramp_cnt_q <= ramp_cnt_d;
      speed_q    <= speed_d;
      a1_q       <= (state_d == ST_RUN) && (drv_d == DRV_FWD);
      a2_q       <= (state_d == ST_RUN) && (drv_d == DRV_REV);
      a3_q       <= (state_d == ST_RUN) && (str_d == STR_LEFT);
      a4_q       <= (state_d == ST_RUN) && (str_d == STR_RIGHT);
      dead_q     <= (state_d == ST_DEAD);
    end
  end

  assign A1           = a1_q;
  assign A2           = a2_q;
  assign A3           = a3_q;
  assign A4           = a4_q;
  assign speed        = speed_q;
  assign dead_active  = dead_q;
  assign wdog_timeout = wdog_to_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Scoreboard bench for drive_sequencer: directed plan scenarios followed
// by random traffic, checked against a cycle-level behavioural model.
module tb_drive_sequencer;

  localparam int DEAD = 4;
  localparam int WDOG = 20;
  localparam int RAMP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       m_cmd_valid = 1'b0;
  logic       m_run = 1'b0, m_backward = 1'b0;
  logic       m_turn_left = 1'b0, m_turn_right = 1'b0;
  logic [1:0] m_speed = 2'b00;
  logic       a_run = 1'b0, a_backward = 1'b0;
  logic       a_turn_left = 1'b0, a_turn_right = 1'b0;
  logic       A1, A2, A3, A4, dead_active, wdog_timeout;
  logic [1:0] speed;

  drive_sequencer #(
    .DEAD_CYCLES(DEAD), .WDOG_CYCLES(WDOG), .RAMP_CYCLES(RAMP)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .m_cmd_valid(m_cmd_valid),
    .m_run(m_run), .m_backward(m_backward),
    .m_turn_left(m_turn_left), .m_turn_right(m_turn_right),
    .m_speed(m_speed),
    .a_run(a_run), .a_backward(a_backward),
    .a_turn_left(a_turn_left), .a_turn_right(a_turn_right),
    .A1(A1), .A2(A2), .A3(A3), .A4(A4), .speed(speed),
    .dead_active(dead_active), .wdog_timeout(wdog_timeout)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Model state: drive/steer 0=stop/none 1=fwd/left 2=rev/right.
  int  md_drv, md_str, md_dead_left, md_idle, md_spd, md_ramp;
  bit  md_to, md_prev_auto;

  function automatic int dec(bit a, bit b);
    if (a && !b) return 1;
    if (!a && b) return 2;
    return 0;
  endfunction

  task automatic model_step(output logic [7:0] e);
    bit auto, blk;
    int rd, rs, tgt;
    if (rst) begin
      md_drv = 0; md_str = 0; md_dead_left = 0; md_idle = 0;
      md_spd = 0; md_ramp = 0; md_to = 1; md_prev_auto = 0;
      e = 8'b0000_00_0_1;
      return;
    end
    auto = (mode == 2'b10);
    blk  = md_to && !auto && !m_cmd_valid;
    rd = blk ? 0 : auto ? dec(a_run, a_backward) : dec(m_run, m_backward);
    rs = blk ? 0 : auto ? dec(a_turn_left, a_turn_right)
                        : dec(m_turn_left, m_turn_right);
    if (m_cmd_valid || auto) md_idle = 0;
    else if (md_idle < WDOG) md_idle++;
    if (m_cmd_valid || auto) md_to = 0;
    else if (md_idle == WDOG) md_to = 1;
    if (md_dead_left > 0) begin
      md_dead_left--;
      if (md_dead_left == 0) begin md_drv = rd; md_str = rs; end
    end else if ((rd != 0 && md_drv != 0 && rd != md_drv) ||
                 (rs != 0 && md_str != 0 && rs != md_str) ||
                 auto != md_prev_auto) begin
      md_dead_left = DEAD;
    end else begin
      md_drv = rd; md_str = rs;
    end
    md_prev_auto = auto;
    tgt = auto ? 3 : int'(m_speed);
    if (md_dead_left > 0 || md_drv == 0) begin
      md_spd = 0; md_ramp = 0;
    end else if (md_spd >= tgt) begin
      md_spd = tgt; md_ramp = 0;
    end else begin
      md_ramp++;
      if (md_ramp == RAMP) begin md_spd++; md_ramp = 0; end
    end
    e[7] = (md_dead_left == 0) && (md_drv == 1);
    e[6] = (md_dead_left == 0) && (md_drv == 2);
    e[5] = (md_dead_left == 0) && (md_str == 1);
    e[4] = (md_dead_left == 0) && (md_str == 2);
    e[3:2] = 2'(md_spd);
    e[1] = (md_dead_left > 0);
    e[0] = md_to;
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic tick();
    logic [7:0] e;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic mcmd(input bit r, input bit b, input bit l, input bit rt,
                      input logic [1:0] s);
    m_run = r; m_backward = b; m_turn_left = l; m_turn_right = rt;
    m_speed = s; m_cmd_valid = 1'b1;
    tick();
    m_cmd_valid = 1'b0;
  endtask

  initial begin : monitor
    logic [7:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {A1, A2, A3, A4, speed, dead_active, wdog_timeout};
        checks++;
        if (got !== e)
          begin
            fails++;
            $display("FAIL cyc%0d outputs{A1A2A3A4,spd,dead,wdog}: got %b expected %b",
                     cyc, got, e);
          end
        cyc++;
      end
    end
  end

  initial begin : stim
    @(negedge clk);
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    // 1: manual forward with ramp to 3
    mcmd(1, 0, 0, 0, 2'b11);
    ticks(10);
    // 2: reversal forces dead time, then re-ramp
    mcmd(0, 1, 0, 0, 2'b11);
    ticks(9);
    // 3: steer flip during a drive reversal's dead period
    mcmd(0, 1, 1, 0, 2'b11);
    ticks(2);
    mcmd(1, 0, 1, 0, 2'b11);
    tick();
    mcmd(1, 0, 0, 1, 2'b11);
    ticks(6);
    // 4: watchdog expiry and recovery
    mcmd(1, 0, 0, 0, 2'b10);
    ticks(25);
    mcmd(1, 0, 0, 0, 2'b10);
    ticks(3);
    // 5: manual to autonomous switch
    mcmd(1, 0, 0, 0, 2'b01);
    ticks(3);
    mode = 2'b10; a_run = 1'b1;
    ticks(45);
    // 6: reset during dead and during ramp, cmd racing expiry
    mode = 2'b00; a_run = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    mcmd(1, 0, 0, 0, 2'b11);
    ticks(2);
    mcmd(0, 1, 0, 0, 2'b11);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    mcmd(1, 0, 0, 0, 2'b11);
    ticks(4);
    rst = 1'b1; tick(); rst = 1'b0;
    mcmd(1, 0, 0, 0, 2'b11);
    ticks(WDOG - 1);
    mcmd(1, 0, 0, 0, 2'b11);
    ticks(3);
    // random traffic
    for (int i = 0; i < 900; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 59) == 0)
        mode = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3))
                                           : (mode == 2'b10 ? 2'b00 : 2'b10);
      if ($urandom_range(0, 7) == 0)
        {a_run, a_backward, a_turn_left, a_turn_right} = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        {m_run, m_backward, m_turn_left, m_turn_right} = 4'($urandom);
        m_speed = 2'($urandom);
        m_cmd_valid = 1'b1;
      end
      tick();
      m_cmd_valid = 1'b0;
    end
    rst = 1'b0;
    @(posedge clk);
    #2;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d pending expected, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
